// File: rtl/bank_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bank_pkg
// Purpose : Shared constants and types for the bank response path and the
//           per-channel reorder buffer (entry layout, pointer type).
// Ports   : none (package)
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
package bank_pkg;

    localparam int ROB_DEPTH   = 8;
    localparam int ROB_IDX_W   = 3;
    localparam int BANK_DATA_W = 128;
    localparam int CH_ID_W     = 2;

    // Index bits plus one wrap bit, so full and empty can be told apart.
    typedef logic [ROB_IDX_W:0] rob_ptr_t;

    typedef struct packed {
        logic                   busy;
        logic                   filled;
        logic [BANK_DATA_W-1:0] data;
    } rob_entry_t;

    function automatic logic [ROB_IDX_W-1:0] ptr_idx(input rob_ptr_t p);
        return p[ROB_IDX_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/channel_rob_ptr.sv
`default_nettype none
// ============================================================================
// Module  : channel_rob_ptr
// Purpose : Wrap-bit ring pointer for the reorder buffer. Increments by one
//           per request and reports full/empty against a peer pointer.
// Ports   : clk, rst_n (async, active-low), inc  - advance pointer
//           peer  - the opposing pointer (head vs tail)
//           ptr   - current pointer value
//           empty - ptr == peer
//           full  - same index, opposite wrap bit
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
module channel_rob_ptr
    import bank_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     inc,
    input  rob_ptr_t peer,
    output rob_ptr_t ptr,
    output logic     empty,
    output logic     full
);

    // Natural binary overflow of the index field toggles the wrap bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + rob_ptr_t'(1);
        end
    end

    assign empty = (ptr == peer);
    assign full  = (ptr_idx(ptr) == ptr_idx(peer)) &&
                   (ptr[ROB_IDX_W] != peer[ROB_IDX_W]);

endmodule
`default_nettype wire

// File: rtl/channel_rob.sv
`default_nettype none
// ============================================================================
// Module  : channel_rob
// Purpose : Per-channel response reorder buffer. Grants 3-bit tags to the
//           channel, accepts tagged bank read responses in any order and
//           returns data to the channel strictly in allocation order,
//           pulsing rob_pop_o once per retirement.
// Ports   : clk_i, rst_i (async, active-low)
//           alloc_valid_i / alloc_ready_o / alloc_rob_num_o - tag allocation
//           bank_rsp_valid_i / _ch_id_i / _rob_num_i / _data_i - bank fills,
//               packed with bank0 in the LSBs, no backpressure
//           rsp_valid_o / rsp_ready_i / rsp_rob_num_o / rsp_data_o - in-order
//               response toward the channel
//           rob_pop_o - registered one-cycle pulse per retirement
//           err_o     - sticky protocol error (bad or duplicate fill)
// Config  : CHANNEL_ROB_BYPASS_EN - when defined, a legal fill of the head
//           entry is presented to the channel combinationally in the same
//           cycle. Undefined (default): all outputs come from storage.
// Revision: 1.0 - initial release
// ============================================================================
module channel_rob
    import bank_pkg::*;
#(
    parameter int CH_ID     = 0,
    parameter int NUM_BANKS = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             alloc_valid_i,
    output logic                             alloc_ready_o,
    output logic [ROB_IDX_W-1:0]             alloc_rob_num_o,
    input  logic [NUM_BANKS-1:0]             bank_rsp_valid_i,
    input  logic [CH_ID_W*NUM_BANKS-1:0]     bank_rsp_ch_id_i,
    input  logic [ROB_IDX_W*NUM_BANKS-1:0]   bank_rsp_rob_num_i,
    input  logic [BANK_DATA_W*NUM_BANKS-1:0] bank_rsp_data_i,
    output logic                             rsp_valid_o,
    input  logic                             rsp_ready_i,
    output logic [ROB_IDX_W-1:0]             rsp_rob_num_o,
    output logic [BANK_DATA_W-1:0]           rsp_data_o,
    output logic                             rob_pop_o,
    output logic                             err_o
);

    localparam logic [CH_ID_W-1:0] MY_CH = CH_ID_W'(CH_ID);

    rob_entry_t             entries [ROB_DEPTH];
    rob_ptr_t               head;
    rob_ptr_t               tail;
    logic                   head_full;
    logic                   head_empty;
    logic                   tail_full;
    logic                   tail_empty;
    logic                   full;
    logic                   empty;
    logic [ROB_IDX_W-1:0]   head_idx;
    logic [ROB_IDX_W-1:0]   tail_idx;
    logic                   alloc_fire;
    logic                   retire_fire;
    logic                   stored_valid;
    logic [NUM_BANKS-1:0]   hit;
    logic [ROB_DEPTH-1:0]   claimed;
    logic [ROB_DEPTH-1:0]   fill_we;
    logic [BANK_DATA_W-1:0] fill_data [ROB_DEPTH];
    logic                   fill_err;
    logic                   pop_q;
    logic                   err_q;

    // ------------------------------------------------------------------
    // Head / tail pointers. Full and empty are symmetric relations, so
    // both instances report the same answer; combining them keeps the two
    // instances identical in use.
    // ------------------------------------------------------------------
    channel_rob_ptr u_head_ptr (
        .clk   (clk_i),
        .rst_n (rst_i),
        .inc   (retire_fire),
        .peer  (tail),
        .ptr   (head),
        .empty (head_empty),
        .full  (head_full)
    );

    channel_rob_ptr u_tail_ptr (
        .clk   (clk_i),
        .rst_n (rst_i),
        .inc   (alloc_fire),
        .peer  (head),
        .ptr   (tail),
        .empty (tail_empty),
        .full  (tail_full)
    );

    assign full     = head_full & tail_full;
    assign empty    = head_empty & tail_empty;
    assign head_idx = ptr_idx(head);
    assign tail_idx = ptr_idx(tail);

    // ------------------------------------------------------------------
    // Allocation: readiness depends only on current occupancy, never on a
    // retirement happening in the same cycle.
    // ------------------------------------------------------------------
    assign alloc_ready_o   = !full;
    assign alloc_rob_num_o = tail_idx;
    assign alloc_fire      = alloc_valid_i & !full;

    // ------------------------------------------------------------------
    // Fill decode. Per entry, the lowest-index hitting bank claims it;
    // any further bank aiming at the same entry is an error. A claim on an
    // entry that is not waiting for data (not busy, or already filled) is
    // an error and writes nothing.
    // ------------------------------------------------------------------
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_hit
        assign hit[b] = bank_rsp_valid_i[b] &&
                        (bank_rsp_ch_id_i[b*CH_ID_W +: CH_ID_W] == MY_CH);
    end

    always_comb begin
        claimed  = '0;
        fill_we  = '0;
        fill_err = 1'b0;
        for (int e = 0; e < ROB_DEPTH; e++) begin
            fill_data[e] = '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (hit[b] &&
                    bank_rsp_rob_num_i[b*ROB_IDX_W +: ROB_IDX_W] == ROB_IDX_W'(e)) begin
                    if (claimed[e]) begin
                        fill_err = 1'b1;
                    end else begin
                        claimed[e]   = 1'b1;
                        fill_data[e] = bank_rsp_data_i[b*BANK_DATA_W +: BANK_DATA_W];
                        if (entries[e].busy && !entries[e].filled) begin
                            fill_we[e] = 1'b1;
                        end else begin
                            fill_err = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response toward the channel.
    // ------------------------------------------------------------------
    assign stored_valid  = !empty && entries[head_idx].busy && entries[head_idx].filled;
    assign rsp_rob_num_o = head_idx;

`ifdef CHANNEL_ROB_BYPASS_EN
    // A legal fill of the head entry can be forwarded straight through.
    // If it is accepted this cycle, the retire clear below overrides the
    // fill, so the entry never shows as filled.
    assign rsp_valid_o = stored_valid | fill_we[head_idx];
    assign rsp_data_o  = stored_valid ? entries[head_idx].data : fill_data[head_idx];
`else
    assign rsp_valid_o = stored_valid;
    assign rsp_data_o  = entries[head_idx].data;
`endif

    assign retire_fire = rsp_valid_o & rsp_ready_i;

    // ------------------------------------------------------------------
    // Entry storage. Order of the updates matters: retire clears last so a
    // bypassed head fill that is accepted in the same cycle leaves nothing
    // behind.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int e = 0; e < ROB_DEPTH; e++) begin
                entries[e] <= '0;
            end
        end else begin
            for (int e = 0; e < ROB_DEPTH; e++) begin
                if (alloc_fire && tail_idx == ROB_IDX_W'(e)) begin
                    entries[e].busy   <= 1'b1;
                    entries[e].filled <= 1'b0;
                end
                if (fill_we[e]) begin
                    entries[e].data   <= fill_data[e];
                    entries[e].filled <= 1'b1;
                end
                if (retire_fire && head_idx == ROB_IDX_W'(e)) begin
                    entries[e].busy   <= 1'b0;
                    entries[e].filled <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pop_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            pop_q <= retire_fire;
            err_q <= err_q | fill_err;
        end
    end

    assign rob_pop_o = pop_q;
    assign err_o     = err_q;

endmodule
`default_nettype wire

// File: doc/channel_rob.md
# channel_rob

Per-channel response reorder buffer that sits directly downstream of the bank response ports (`bank_sc_xbar_*`). It hands out 3-bit ROB tags when a channel issues a request toward the banks. It accepts bank read responses out of order, tagged by `rob_num`, and returns data to the channel strictly in allocation order. On each retirement it emits the per-channel pop pulse that the banks consume on `channel_spw_pop_i`.

## Interface
Parameters:
- `CH_ID`, 0 — channel this instance serves; bank responses with any other `ch_id` are ignored.
- `NUM_BANKS`, 2 — number of bank response ports.

Ports (clock and reset first):
- `clk_i` in 1 — single clock.
- `rst_i` in 1 — reset, asynchronous, active-low.
- `alloc_valid_i` in 1 — channel wants a tag.
- `alloc_ready_o` out 1 — a tag is available.
- `alloc_rob_num_o` out 3 — tag granted on `alloc_valid_i & alloc_ready_o`.
- `bank_rsp_valid_i` in NUM_BANKS — per-bank response valid. No backpressure.
- `bank_rsp_ch_id_i` in 2*NUM_BANKS — per-bank `ch_id`, packed with bank0 in the LSBs.
- `bank_rsp_rob_num_i` in 3*NUM_BANKS — per-bank tag.
- `bank_rsp_data_i` in 128*NUM_BANKS — per-bank data.
- `rsp_valid_o` out 1 — head entry data valid toward the channel.
- `rsp_ready_i` in 1 — channel accepts.
- `rsp_rob_num_o` out 3 — tag of the head entry.
- `rsp_data_o` out 128 — head data.
- `rob_pop_o` out 1 — one-cycle pulse per retirement; drives `channel_spw_pop_i[CH_ID]`.
- `err_o` out 1 — sticky protocol error.

## Operation
- **Storage:** 8 entries, each holding a `busy` bit, a `filled` bit and 128-bit data.
- **Pointers:** `tail` (alloc) and `head` (retire) are 4 bits, 3 index bits plus a wrap bit.
  - Empty: `head == tail`.
  - Full: index bits equal and wrap bits differ.
- **Alloc:**
  - `alloc_ready_o = !full`. It does not depend on a same-cycle retirement.
  - `alloc_rob_num_o = tail[2:0]`.
  - On fire: `busy[tail]` is set, `filled[tail]` is cleared, `tail` increments and wraps 7→0 with the wrap bit toggled.
- **Fill:**
  - A bank port hits when `bank_rsp_valid_i[b]` is set and its `ch_id == CH_ID`.
  - On a hit, the data is written and `filled[rob_num]` is set.
  - Fill to an entry with `busy=0` or already `filled=1`: no write, `err_o` set.
  - Two ports targeting the same entry in one cycle: the lowest-index bank writes, and `err_o` is set.
  - Different entries from different ports in the same cycle: all are written.
- **Retire:**
  - `rsp_valid_o = busy[head] & filled[head]`.
  - On `rsp_valid_o & rsp_ready_i`: `busy[head]` and `filled[head]` are cleared, `head` increments, and `rob_pop_o` pulses in the next cycle (registered).
  - Retirement is at most one per cycle.
- **Data hold:** `rsp_data_o` and `rsp_rob_num_o` stay stable while `rsp_valid_o=1` and `rsp_ready_i=0`.
- **Simultaneous events:**
  - Alloc and retire may occur in the same cycle.
  - A fill and a retire to different entries may occur in the same cycle.
  - Alloc of an entry cannot coincide with its fill, because the entry was not busy; such a fill is an error.
- **`err_o`:** cleared only by reset.

## Timing
- **Reset values:**
  - `alloc_ready_o=1`, `alloc_rob_num_o=0`.
  - `rsp_valid_o=0`, `rsp_rob_num_o=0`, `rsp_data_o=0`.
  - `rob_pop_o=0`, `err_o=0`.
  - All `busy`/`filled` bits cleared; `head=tail=0`.
- **Reset mid-operation:** everything is dropped. Responses arriving after reset release target non-busy entries and set `err_o`; upstream must be quiesced.
- **Fill to response latency:** a fill of the head entry in cycle N gives `rsp_valid_o` in cycle N+1 (default build).
- **Alloc:** a tag granted in cycle N is busy from cycle N+1.
- **Pop pulse:** `rob_pop_o` asserts in the cycle after the retire handshake, one pulse per retire.

## Configuration
- **`CHANNEL_ROB_BYPASS_EN` defined:**
  - A fill hitting `head` with `busy[head]=1` drives `rsp_valid_o` and `rsp_data_o` combinationally in the same cycle N, from the lowest-index hitting bank.
  - If that response is accepted in cycle N, the entry is never marked filled.
  - If it is not accepted, the data is stored as normal and presented from storage from cycle N+1.
- **`CHANNEL_ROB_BYPASS_EN` undefined:** all outputs come from registered storage, with a 1-cycle fill-to-response latency.

## Structure
- **Shared package `bank_pkg`** holds:
  - `ROB_DEPTH=8`, `ROB_IDX_W=3`, `BANK_DATA_W=128`, `CH_ID_W=2`.
  - Typedef `rob_ptr_t` (ROB_IDX_W+1 bits).
  - Typedef `rob_entry_t` (busy, filled, data).
- **Sub-module `channel_rob_ptr`:** wrap-bit pointer with increment; instantiated for `head` and `tail`, and also provides the full/empty compare.

## Test plan
1. **Fill allocation:** 8 allocs with no retire → tags 0..7 granted, then `alloc_ready_o=0`; one retire → `alloc_ready_o=1` the next cycle, and the next tag is 0.
2. **Out-of-order fill:** alloc tags 0,1,2; bank1 fills 2, bank0 fills 1, then fills 0 → channel receives 0,1,2 in order; `rob_pop_o` pulses 3 times.
3. **Parallel fill and filtering:** bank0 and bank1 fill tags 3 and 5 in the same cycle with `CH_ID=1`, plus a `ch_id=2` response to tag 4 → 3 and 5 are stored; tag 4 is untouched and `err_o` stays 0.
4. **Protocol errors:** fill of an unallocated tag 6 → `err_o=1` and no response produced; duplicate fill of tag 0 → `err_o=1` and the original data is kept.
5. **Backpressure and wrap:** `rsp_ready_i=0` for 5 cycles with the head filled (data `0xDEAD…`) → outputs stable; then 20 alloc/fill/retire rounds → tags wrap 7→0 and order is preserved.
6. **Reset and bypass:** async reset asserted mid-burst → all outputs reach reset values without a clock edge. With `CHANNEL_ROB_BYPASS_EN`, a head fill plus `rsp_ready_i=1` → response in the same cycle.
